// File: rtl/serial_rx_8.sv
// LSB-first serial-to-parallel receiver with a holding register, valid/ack handshake
// and a sticky overrun flag for words dropped while the holding register is occupied.
module serial_rx_8 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Serial_In,
    input  logic             Bit_En,
    input  logic             Frame_Start,
    input  logic             Data_Ack,
    input  logic             Overrun_Clr,
    output logic [WIDTH-1:0] Data_Out,
    output logic             Data_Valid,
    output logic             Busy,
    output logic [4:0]       Bit_Count,
    output logic             Overrun
);

    typedef enum logic {StIdle, StShift} state_e;

    localparam logic [4:0] LastBit = 5'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             complete;
    logic [WIDTH-1:0] shifted;

    assign shifted = {Serial_In, sr_q[WIDTH-1:1]};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            sr_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    // Frame FSM: collects bits into sr, flags completion on the last bit.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        complete = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (Frame_Start) begin
                    state_d = StShift;
                    sr_d    = '0;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                if (Frame_Start) begin
                    sr_d  = '0;
                    cnt_d = '0;
                end else if (Bit_En) begin
                    sr_d = shifted;
                    if (cnt_q == LastBit) begin
                        complete = 1'b1;
                        cnt_d    = '0;
                        state_d  = StIdle;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Holding stage: an ack in the completion cycle frees the slot for the new word.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (Overrun_Clr) begin
            ovr_d = 1'b0;
        end
        if (complete) begin
            if (!valid_q || Data_Ack) begin
                data_d  = shifted;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && Data_Ack) begin
            valid_d = 1'b0;
        end
    end

    assign Data_Out   = data_q;
    assign Data_Valid = valid_q;
    assign Busy       = (state_q == StShift);
    assign Bit_Count  = cnt_q;
    assign Overrun    = ovr_q;

endmodule

// File: tb/tb_serial_rx_8.sv
// Directed bench for serial_rx_8: receive, gaps, handshake, overrun, restart and reset.
module tb_serial_rx_8;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Serial_In = 1'b0;
    logic       Bit_En = 1'b0;
    logic       Frame_Start = 1'b0;
    logic       Data_Ack = 1'b0;
    logic       Overrun_Clr = 1'b0;
    logic [7:0] Data_Out;
    logic       Data_Valid;
    logic       Busy;
    logic [4:0] Bit_Count;
    logic       Overrun;

    int n_checks = 0;
    int n_fail   = 0;

    serial_rx_8 #(.WIDTH(8)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Serial_In   (Serial_In),
        .Bit_En      (Bit_En),
        .Frame_Start (Frame_Start),
        .Data_Ack    (Data_Ack),
        .Overrun_Clr (Overrun_Clr),
        .Data_Out    (Data_Out),
        .Data_Valid  (Data_Valid),
        .Busy        (Busy),
        .Bit_Count   (Bit_Count),
        .Overrun     (Overrun)
    );

    always #5 Clk = ~Clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("%s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic frame_start();
        Frame_Start = 1'b1;
        tick();
        Frame_Start = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic ack);
        Serial_In = b;
        Bit_En    = 1'b1;
        Data_Ack  = ack;
        tick();
        Bit_En    = 1'b0;
        Data_Ack  = 1'b0;
    endtask

    // n bits of v, LSB first, with gap idle cycles between bits; ack on the last bit.
    task automatic send_bits(input logic [7:0] v, input int n, input int gap, input logic ack);
        for (int i = 0; i < n; i++) begin
            send_bit(v[i], ack && (i == n - 1));
            if (i != n - 1) repeat (gap) tick();
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap, input logic ack);
        frame_start();
        send_bits(v, 8, gap, ack);
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        Reset = 1'b0;
        chk("rst_data", 16'(Data_Out), 16'h00);
        chk("rst_valid", 16'(Data_Valid), 16'h0);
        chk("rst_busy", 16'(Busy), 16'h0);
        chk("rst_count", 16'(Bit_Count), 16'h0);
        chk("rst_ovr", 16'(Overrun), 16'h0);

        // Basic receive of 0xA5
        frame_start();
        chk("start_busy", 16'(Busy), 16'h1);
        send_bits(8'hA5, 8, 0, 1'b0);
        chk("basic_data", 16'(Data_Out), 16'hA5);
        chk("basic_valid", 16'(Data_Valid), 16'h1);
        chk("basic_busy", 16'(Busy), 16'h0);
        chk("basic_count", 16'(Bit_Count), 16'h0);
        chk("basic_ovr", 16'(Overrun), 16'h0);
        Data_Ack = 1'b1;
        tick();
        Data_Ack = 1'b0;
        chk("ack1_valid", 16'(Data_Valid), 16'h0);

        // Gapped bits then handshake
        frame_start();
        send_bits(8'hA5, 3, 3, 1'b0);
        repeat (2) tick();
        chk("gap_count", 16'(Bit_Count), 16'h3);
        send_bits(8'hA5 >> 3, 5, 3, 1'b0);
        chk("gap_data", 16'(Data_Out), 16'hA5);
        chk("gap_valid", 16'(Data_Valid), 16'h1);
        chk("gap_busy", 16'(Busy), 16'h0);
        Data_Ack = 1'b1;
        tick();
        Data_Ack = 1'b0;
        chk("ack2_valid", 16'(Data_Valid), 16'h0);

        // Overrun: second word dropped while the first is pending
        send_byte(8'h3C, 0, 1'b0);
        chk("ovr_first", 16'(Data_Out), 16'h3C);
        send_byte(8'hC3, 0, 1'b0);
        chk("ovr_data", 16'(Data_Out), 16'h3C);
        chk("ovr_valid", 16'(Data_Valid), 16'h1);
        chk("ovr_flag", 16'(Overrun), 16'h1);
        tick();
        chk("ovr_sticky", 16'(Overrun), 16'h1);
        Overrun_Clr = 1'b1;
        tick();
        Overrun_Clr = 1'b0;
        chk("ovr_clr", 16'(Overrun), 16'h0);

        // Ack in the completion cycle replaces the pending word
        send_byte(8'h81, 0, 1'b1);
        chk("sim_data", 16'(Data_Out), 16'h81);
        chk("sim_valid", 16'(Data_Valid), 16'h1);
        chk("sim_ovr", 16'(Overrun), 16'h0);
        Data_Ack = 1'b1;
        tick();
        Data_Ack = 1'b0;
        chk("ack3_valid", 16'(Data_Valid), 16'h0);

        // Abort/restart; the restart cycle also carries a Bit_En that must be ignored
        frame_start();
        send_bits(8'hFF, 4, 0, 1'b0);
        chk("abort_count4", 16'(Bit_Count), 16'h4);
        Frame_Start = 1'b1;
        Bit_En      = 1'b1;
        Serial_In   = 1'b1;
        tick();
        Frame_Start = 1'b0;
        Bit_En      = 1'b0;
        chk("abort_count0", 16'(Bit_Count), 16'h0);
        chk("abort_busy", 16'(Busy), 16'h1);
        send_bits(8'h0F, 8, 0, 1'b0);
        chk("abort_data", 16'(Data_Out), 16'h0F);
        chk("abort_valid", 16'(Data_Valid), 16'h1);

        // Reset mid-frame with a pending word
        frame_start();
        send_bits(8'h15, 5, 0, 1'b0);
        chk("mid_count5", 16'(Bit_Count), 16'h5);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("mrst_data", 16'(Data_Out), 16'h00);
        chk("mrst_valid", 16'(Data_Valid), 16'h0);
        chk("mrst_busy", 16'(Busy), 16'h0);
        chk("mrst_count", 16'(Bit_Count), 16'h0);
        chk("mrst_ovr", 16'(Overrun), 16'h0);
        send_bits(8'hFF, 3, 0, 1'b0);
        chk("idle_count", 16'(Bit_Count), 16'h0);
        chk("idle_busy", 16'(Busy), 16'h0);
        chk("idle_valid", 16'(Data_Valid), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
